pipe_stage_buf: RTL and testbench

Parametrised, elastic pipeline-stage register. It is the generic successor to the fixed stage-to-stage latches between IF/ID/EX/MEM/WB.
- Carries a control field and a data field between stages under a valid/ready handshake.
- Supports stall (backpressure) and synchronous flush.
- Zeroes control bits on bubbles so a squashed slot can never write the register file or halt the core.
- A SKID option adds a second entry, which registers in_ready and breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 65 ++++++
 rtl/pipe_stage_buf.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage buffers: stage occupancy state,
// control/data layouts and default field widths per stage boundary.
package pipe_pkg;

  // Stage occupancy; the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Control bits shared by every boundary; hlt is the MSB, we is bit 2.
  typedef struct packed {
    logic hlt;
    logic mov_sel;
    logic we;
    logic pc_sel;
    logic mem_sel;
  } stage_ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [21:0] pc;
  } if_id_data_t;

  typedef struct packed {
    logic [4:0]  dst_reg;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [21:0] pc;
  } id_ex_data_t;

  typedef struct packed {
    logic [4:0]  dst_reg;
    logic [31:0] mov;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [21:0] pc;
  } ex_mem_data_t;

  typedef struct packed {
    logic [4:0]  dst_reg;
    logic [31:0] wdata;
    logic [21:0] pc;
  } mem_wb_data_t;

  localparam int STAGE_CTRL_W  = $bits(stage_ctrl_t);

  localparam int IF_ID_CTRL_W  = STAGE_CTRL_W;
  localparam int ID_EX_CTRL_W  = STAGE_CTRL_W;
  localparam int EX_MEM_CTRL_W = STAGE_CTRL_W;
  localparam int MEM_WB_CTRL_W = STAGE_CTRL_W;

  localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
  localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);

  // True when a control word cannot cause any architectural side effect.
  function automatic logic ctrl_is_bubble(input stage_ctrl_t c);
    return (c == '0);
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and
// bubble gating of the control field. SKID=0 is a single entry with
// combinational ready; SKID=1 is a two-entry skid buffer with ready taken
// straight from the occupancy state flop.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = STAGE_CTRL_W,
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  if (SKID == 0) begin : g_single

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_issue;

    assign w_in_ready = ~r_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;
    assign w_issue    = r_valid & out_ready;

    // Occupancy flag: an accept refills the slot even while it issues.
    always_ff @(posedge clk) begin
      if (rst)           r_valid <= 1'b0;
      else if (flush)    r_valid <= 1'b0;
      else if (w_accept) r_valid <= 1'b1;
      else if (w_issue)  r_valid <= 1'b0;
    end

    // Payload capture; a flushed accept never lands, data holds on flush.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_ctrl <= '0;
        r_data <= '0;
      end else if (w_accept && !flush) begin
        r_ctrl <= in_ctrl;
        r_data <= in_data;
      end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_ctrl  = r_valid ? r_ctrl : '0;
    assign out_data  = r_data;
    assign occ       = {1'b0, r_valid};

  end else begin : g_skid

    stage_state_e      r_state;
    stage_state_e      w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_issue;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    // Ready depends only on the state flop, so out_ready never reaches it.
    assign w_in_ready  = (r_state != FULL);
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_issue     = w_out_valid & out_ready;

    // Next occupancy and which register loads from where.
    always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ONE;
            w_load_main_in = 1'b1;
          end
        end
        ONE: begin
          case ({w_accept, w_issue})
            2'b11: w_load_main_in = 1'b1;
            2'b10: begin
              w_state_nxt = FULL;
              w_load_skid = 1'b1;
            end
            2'b01: w_state_nxt = EMPTY;
            default: w_state_nxt = ONE;
          endcase
        end
        FULL: begin
          if (w_issue) begin
            w_state_nxt      = ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
      if (flush) begin
        w_state_nxt      = EMPTY;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
      end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else     r_state <= w_state_nxt;
    end

    // Main entry: refilled from the input or promoted from the skid entry.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_main_ctrl <= '0;
        r_main_data <= '0;
      end else if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
    end

    // Skid entry catches the word that arrives while main is stalled.
    always_ff @(posedge clk) begin
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occ       = r_state;

  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=0 and one SKID=1 instance share the
// same stimulus; each is compared every cycle against a small FIFO model.
module tb_pipe_stage_buf;

  localparam int CW = 5;
  localparam int DW = 123;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy0, vld0, rdy1, vld1;
  logic [CW-1:0] ctl0, ctl1;
  logic [DW-1:0] dat0, dat1;
  logic [1:0]    occ0, occ1;

  int cmp = 0;
  int errs = 0;
  int xfer1 = 0;
  bit started = 0;
  string phase = "reset";

  item_t         mb [2][2];
  int            mn [2];
  logic [DW-1:0] mlast [2];

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_ctrl(ctl0), .out_data(dat0),
    .occ(occ0)
  );

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_ctrl(ctl1), .out_data(dat1),
    .occ(occ1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acceptance rule: one slot (or one freed by issue) vs two registered slots.
  function automatic logic exp_rdy(input int k);
    if (k == 0) return (mn[0] == 0) || out_ready;
    return (mn[1] < 2);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic acc, iss;
      acc = in_valid && exp_rdy(k);
      iss = (mn[k] > 0) && out_ready;
      if (rst) begin
        mn[k] = 0;
        mlast[k] = '0;
      end else if (flush) begin
        mn[k] = 0;
      end else begin
        if (iss) begin
          mb[k][0] = mb[k][1];
          mn[k]--;
          if (k == 1) xfer1++;
        end
        if (acc) begin
          mb[k][mn[k]] = '{c: in_ctrl, d: in_data};
          mn[k]++;
        end
      end
      if (mn[k] > 0) mlast[k] = mb[k][0].d;
    end
  endtask

  task automatic check_out();
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    for (int k = 0; k < 2; k++) begin
      string s;
      s = (k == 0) ? {phase, "/s0"} : {phase, "/s1"};
      ec = (mn[k] > 0) ? mb[k][0].c : '0;
      ed = (mn[k] > 0) ? mb[k][0].d : mlast[k];
      if (k == 0) begin
        chk({s, " out_valid"}, 128'(vld0), 128'(mn[0] > 0));
        chk({s, " out_ctrl"},  128'(ctl0), 128'(ec));
        chk({s, " out_data"},  128'(dat0), 128'(ed));
        chk({s, " occ"},       128'(occ0), 128'(mn[0]));
      end else begin
        chk({s, " out_valid"}, 128'(vld1), 128'(mn[1] > 0));
        chk({s, " out_ctrl"},  128'(ctl1), 128'(ec));
        chk({s, " out_data"},  128'(dat1), 128'(ed));
        chk({s, " occ"},       128'(occ1), 128'(mn[1]));
      end
    end
  endtask

  // One clock: check ready with current inputs, advance the model, check outputs.
  task automatic tick();
    #1;
    if (started) begin
      chk({phase, "/s0 in_ready"}, 128'(rdy0), 128'(exp_rdy(0)));
      chk({phase, "/s1 in_ready"}, 128'(rdy1), 128'(exp_rdy(1)));
      out_ready = ~out_ready;
      #1;
      chk({phase, "/s1 in_ready vs out_ready"}, 128'(rdy1), 128'(exp_rdy(1)));
      out_ready = ~out_ready;
      #1;
    end
    model_step();
    @(posedge clk);
    #1;
    started = 1;
    check_out();
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    logic [127:0] r128;
    int budget;
    mn[0] = 0; mn[1] = 0;
    mlast[0] = '0; mlast[1] = '0;
    rst = 1'b1;

    // Reset with a live upstream; the slot must stay empty.
    drive(1'b1, 5'h1F, 123'h5A5, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset out_ctrl s1", 128'(ctl1), 128'(0));
    rst = 1'b0;
    drive(1'b0, 5'h1F, 123'h5A5, 1'b0, 1'b0);
    tick();

    // Streaming 1..4 at full rate.
    phase = "stream";
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'h01, DW'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 5'h00, '0, 1'b1, 1'b0);
    tick();
    tick();

    // Stall: A and B with no downstream room, then drain.
    phase = "stall";
    drive(1'b1, 5'h02, 123'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'h03, 123'hB, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'h00, '0, 1'b0, 1'b0);
    tick();
    chk("stall occ s1", 128'(occ1), 128'(2));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'h00, '0, 1'b1, 1'b0);
      tick();
    end

    // Flush a full stage while a word with data 7 is offered.
    phase = "flush";
    drive(1'b1, 5'h04, 123'h21, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'h04, 123'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'h04, 123'h7, 1'b0, 1'b1);
    tick();
    chk("flush out_valid s1", 128'(vld1), 128'(0));
    drive(1'b0, 5'h00, '0, 1'b1, 1'b0);
    tick();
    tick();

    // Bubble gating after a hlt word drains.
    phase = "bubble";
    drive(1'b1, 5'h10, 123'h99, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'h1F, 123'h55, 1'b1, 1'b0);
      tick();
    end

    // Randomised traffic with backpressure, occasional flush and reset.
    phase = "random";
    xfer1 = 0;
    budget = 0;
    while (xfer1 < 1000 && budget < 20000) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom % 4) != 0, CW'($urandom), r128[DW-1:0],
            ($urandom % 10) < 6, ($urandom % 200) == 0);
      rst = (($urandom % 500) == 0);
      tick();
      budget++;
    end
    rst = 1'b0;
    chk("random transfers reached", 128'(xfer1 >= 1000), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
